// File: rtl/tap_product_stage.sv
// tap_product_stage: LEN-deep sample delay line times LEN-entry coefficient bank, one registered Q-format product per tap.
// Latency: x_in accepted at edge E0 lands in tap[0]; products are registered at E1; prod_valid is high for the cycle after E1.
// Backpressure: none. Every accept overwrites prod_packed one edge later. Build option PROD_SAT_EN saturates products; otherwise they wrap.
module tap_product_stage #(
   parameter int WIDTH = 16,
   parameter int LEN   = 1024,
   parameter int FRAC  = 12
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic signed [WIDTH-1:0]  x_in,
   input  logic                     x_valid,
   input  logic                     w_wr_en,
   input  logic [$clog2(LEN)-1:0]   w_wr_addr,
   input  logic signed [WIDTH-1:0]  w_wr_data,
   output logic [LEN*WIDTH-1:0]     prod_packed,
   output logic                     prod_valid,
   output logic                     primed
);

   localparam int AW = $clog2(LEN);
   localparam logic [AW:0] C_FULL = (AW+1)'(LEN);

   logic signed [WIDTH-1:0] r_tap [LEN];
   logic signed [WIDTH-1:0] r_w   [LEN];
   logic [LEN*WIDTH-1:0]    r_prod;
   logic [AW:0]             r_fill;
   logic [AW:0]             w_fill_nxt;
   logic                    r_acc_d;
   logic                    r_prod_valid;
   logic                    r_primed;

   // Full-precision product, floor shift by FRAC, then reduce to WIDTH bits.
   function automatic logic [WIDTH-1:0] f_reduce(input logic signed [WIDTH-1:0] a,
                                                 input logic signed [WIDTH-1:0] b);
      logic signed [2*WIDTH-1:0] p;
      logic signed [2*WIDTH-1:0] s;
      p = a * b;
      s = p >>> FRAC;
`ifdef PROD_SAT_EN
      if (s > $signed({{(WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}}))
         s = $signed({{(WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}});
      else if (s < $signed({{(WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}}))
         s = $signed({{(WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}});
`endif
      return s[WIDTH-1:0];
   endfunction

   // Fill count only advances on accepts and sticks at LEN.
   always_comb begin
      w_fill_nxt = r_fill;
      if (x_valid && (r_fill != C_FULL))
         w_fill_nxt = r_fill + 1'b1;
   end

   // Delay line: shift in a new sample on every accept, hold otherwise.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int k = 0; k < LEN; k++)
            r_tap[k] <= '0;
      end else if (x_valid) begin
         r_tap[0] <= x_in;
         for (int k = 1; k < LEN; k++)
            r_tap[k] <= r_tap[k-1];
      end
   end

   // Coefficient bank: single write port, independent of sample accepts.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int k = 0; k < LEN; k++)
            r_w[k] <= '0;
      end else if (w_wr_en) begin
         r_w[w_wr_addr] <= w_wr_data;
      end
   end

   // Products register one edge after an accept, from the shifted taps and the coefficients as they stand now.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_prod <= '0;
      end else if (r_acc_d) begin
         for (int k = 0; k < LEN; k++)
            r_prod[WIDTH*k +: WIDTH] <= f_reduce(r_tap[k], r_w[k]);
      end
   end

   // Fill tracking and flags; prod_valid marks products taken from a full window.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_fill       <= '0;
         r_acc_d      <= 1'b0;
         r_prod_valid <= 1'b0;
         r_primed     <= 1'b0;
      end else begin
         r_fill       <= w_fill_nxt;
         r_acc_d      <= x_valid;
         r_prod_valid <= r_acc_d && (r_fill == C_FULL);
         r_primed     <= (w_fill_nxt == C_FULL);
      end
   end

   assign prod_packed = r_prod;
   assign prod_valid  = r_prod_valid;
   assign primed      = r_primed;

endmodule
